// File: rtl/line_prefetcher.sv
`default_nettype none
// ============================================================================
// Module      : line_prefetcher
// Description : Next-line instruction prefetcher with a one-line buffer
//               between the icache fill port and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module line_prefetcher #(
    parameter logic PF_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  up_addr,
    input  logic         up_read,
    output logic [255:0] up_rdata,
    output logic         up_resp,
    input  logic         miss_complete,
    input  logic [31:0]  next_line_addr,
    output logic [31:0]  mem_addr,
    output logic         mem_read,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp,
    output logic         pf_hit
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEMAND   = 2'd1,
        PREFETCH = 2'd2,
        HIT      = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_pf_valid;
    logic [26:0]    r_pf_tag;
    logic [255:0]   r_pf_data;
    logic           r_pend_valid;
    logic [26:0]    r_pend_tag;
    logic [26:0]    r_mem_tag;

    logic [26:0]    w_up_tag;
    logic           w_buf_hit;
    logic           w_pend_dup;
    logic           w_pf_claim;
    logic           w_trigger;
    logic           w_unused_bits;

    assign w_up_tag      = up_addr[31:5];
    assign w_buf_hit     = r_pf_valid && (w_up_tag == r_pf_tag);
    assign w_pend_dup    = r_pf_valid && (r_pend_tag == r_pf_tag);
    // A demand that shows up during a prefetch of the same line takes the data directly
    assign w_pf_claim    = up_read && (w_up_tag == r_mem_tag);
    assign w_trigger     = PF_EN && miss_complete;
    assign w_unused_bits = ^{up_addr[4:0], next_line_addr[4:0]};

    always_comb begin
        w_state_nxt = r_state;
        up_resp     = 1'b0;
        up_rdata    = '0;
        pf_hit      = 1'b0;
        mem_read    = 1'b0;
        mem_addr    = '0;
        case (r_state)
            IDLE: begin
                if (up_read) begin
                    w_state_nxt = w_buf_hit ? HIT : DEMAND;
                end else if (r_pend_valid && !w_pend_dup) begin
                    w_state_nxt = PREFETCH;
                end
            end
            DEMAND: begin
                mem_read = 1'b1;
                mem_addr = {r_mem_tag, 5'b0};
                if (mem_resp) begin
                    up_resp     = 1'b1;
                    up_rdata    = mem_rdata;
                    w_state_nxt = IDLE;
                end
            end
            PREFETCH: begin
                mem_read = 1'b1;
                mem_addr = {r_mem_tag, 5'b0};
                if (mem_resp) begin
                    if (w_pf_claim) begin
                        up_resp  = 1'b1;
                        up_rdata = mem_rdata;
                        pf_hit   = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
            end
            HIT: begin
                up_resp     = 1'b1;
                up_rdata    = r_pf_data;
                pf_hit      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_pf_valid   <= 1'b0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == HIT) begin
                r_pf_valid <= 1'b0;
            end else if ((r_state == PREFETCH) && mem_resp) begin
                r_pf_valid <= !w_pf_claim;
            end
            // A fresh trigger wins over consumption of the older one
            if (w_trigger) begin
                r_pend_valid <= 1'b1;
            end else if ((r_state == IDLE) && !up_read) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_trigger) begin
            r_pend_tag <= next_line_addr[31:5];
        end
        if (r_state == IDLE) begin
            r_mem_tag <= up_read ? w_up_tag : r_pend_tag;
        end
        if ((r_state == PREFETCH) && mem_resp && !w_pf_claim) begin
            r_pf_tag  <= r_mem_tag;
            r_pf_data <= mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_prefetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_prefetcher
// Description : Directed and randomized self-checking bench for line_prefetcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_prefetcher;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  up_addr = '0;
    logic         up_read = 1'b0;
    logic [255:0] up_rdata;
    logic         up_resp;
    logic         miss_complete = 1'b0;
    logic [31:0]  next_line_addr = '0;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;
    logic         pf_hit;

    always #5 clk = ~clk;

    line_prefetcher #(.PF_EN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .up_addr        (up_addr),
        .up_read        (up_read),
        .up_rdata       (up_rdata),
        .up_resp        (up_resp),
        .miss_complete  (miss_complete),
        .next_line_addr (next_line_addr),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .pf_hit         (pf_hit)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Literal expectations posted by the directed sequence, checked at the next negedge
    int           lit_seq = 0;
    string        lit_name = "";
    logic         lit_resp = 1'b0;
    logic         lit_hit = 1'b0;
    logic         lit_mread = 1'b0;
    logic [31:0]  lit_addr = '0;
    logic [255:0] lit_data = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] b;
        case ($urandom_range(0, 6))
            0: b = 32'h0000_1000;
            1: b = 32'h0000_1020;
            2: b = 32'h0000_2000;
            3: b = 32'h0000_0000;
            4: b = 32'hFFFF_FFE0;
            5: b = 32'h0000_1040;
            default: b = $urandom;
        endcase
        return b | ($urandom & 32'h1F);
    endfunction

    // Reference model: buffer contents, pending trigger and the one outstanding job
    initial begin : compare
        bit           m_pf_v = 0;
        logic [26:0]  m_pf_tag = '0;
        logic [255:0] m_pf_data = '0;
        bit           m_pend_v = 0;
        logic [26:0]  m_pend_tag = '0;
        int           m_job = 0;          // 0 none, 1 demand read, 2 prefetch read
        logic [26:0]  m_job_tag = '0;
        bit           m_serve_buf = 0;
        int           last_seq = 0;
        logic         e_resp, e_hit, e_mread;
        logic [31:0]  e_addr;
        logic [255:0] e_data;
        bit           claim;
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                #1;
                m_pf_v = 0; m_pend_v = 0; m_job = 0; m_serve_buf = 0;
                chk("rst_up_resp", 256'(up_resp), '0);
                chk("rst_up_rdata", up_rdata, '0);
                chk("rst_pf_hit", 256'(pf_hit), '0);
                chk("rst_mem_read", 256'(mem_read), '0);
                chk("rst_mem_addr", 256'(mem_addr), '0);
            end else begin
                e_resp = 0; e_hit = 0; e_mread = 0; e_addr = '0; e_data = '0;
                claim = up_read && (up_addr[31:5] == m_job_tag);
                if (m_serve_buf) begin
                    e_resp = 1; e_hit = 1; e_data = m_pf_data;
                end else if (m_job != 0) begin
                    e_mread = 1;
                    e_addr  = {m_job_tag, 5'b0};
                    if (mem_resp && (m_job == 1)) begin
                        e_resp = 1; e_data = mem_rdata;
                    end else if (mem_resp && claim) begin
                        e_resp = 1; e_hit = 1; e_data = mem_rdata;
                    end
                end
                chk("up_resp", 256'(up_resp), 256'(e_resp));
                chk("up_rdata", up_rdata, e_data);
                chk("pf_hit", 256'(pf_hit), 256'(e_hit));
                chk("mem_read", 256'(mem_read), 256'(e_mread));
                chk("mem_addr", 256'(mem_addr), 256'(e_addr));
                if (lit_seq != last_seq) begin
                    last_seq = lit_seq;
                    chk({lit_name, ".up_resp"}, 256'(up_resp), 256'(lit_resp));
                    chk({lit_name, ".pf_hit"}, 256'(pf_hit), 256'(lit_hit));
                    chk({lit_name, ".mem_read"}, 256'(mem_read), 256'(lit_mread));
                    chk({lit_name, ".mem_addr"}, 256'(mem_addr), 256'(lit_addr));
                    chk({lit_name, ".up_rdata"}, up_rdata, lit_data);
                end
                // Advance the model to what holds after the coming rising edge
                if (m_serve_buf) begin
                    m_serve_buf = 0;
                    m_pf_v = 0;
                end else if (m_job != 0) begin
                    if (mem_resp) begin
                        if (m_job == 2) begin
                            if (claim) m_pf_v = 0;
                            else begin
                                m_pf_v = 1; m_pf_tag = m_job_tag; m_pf_data = mem_rdata;
                            end
                        end
                        m_job = 0;
                    end
                end else if (up_read) begin
                    if (m_pf_v && (up_addr[31:5] == m_pf_tag)) m_serve_buf = 1;
                    else begin
                        m_job = 1; m_job_tag = up_addr[31:5];
                    end
                end else if (m_pend_v) begin
                    m_pend_v = 0;
                    if (!(m_pf_v && (m_pend_tag == m_pf_tag))) begin
                        m_job = 2; m_job_tag = m_pend_tag;
                    end
                end
                if (miss_complete) begin
                    m_pend_v = 1; m_pend_tag = next_line_addr[31:5];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string nm, input logic r, input logic h, input logic mr,
                            input logic [31:0] a, input logic [255:0] d);
        lit_name = nm; lit_resp = r; lit_hit = h; lit_mread = mr; lit_addr = a; lit_data = d;
        lit_seq++;
        @(negedge clk);
    endtask

    task automatic demand_txn(input string nm, input logic [31:0] a, input logic [255:0] d);
        tick(); up_read = 1'b1; up_addr = a;
        expect_o({nm, "_req"}, 0, 0, 0, '0, '0);
        tick();
        expect_o({nm, "_mem"}, 0, 0, 1, {a[31:5], 5'b0}, '0);
        tick(); mem_resp = 1'b1; mem_rdata = d;
        expect_o({nm, "_resp"}, 1, 0, 1, {a[31:5], 5'b0}, d);
        tick(); mem_resp = 1'b0; up_read = 1'b0;
        expect_o({nm, "_done"}, 0, 0, 0, '0, '0);
    endtask

    task automatic hit_txn(input string nm, input logic [31:0] a, input logic [255:0] d);
        tick(); up_read = 1'b1; up_addr = a;
        expect_o({nm, "_req"}, 0, 0, 0, '0, '0);
        tick();
        expect_o({nm, "_resp"}, 1, 1, 0, '0, d);
        tick(); up_read = 1'b0;
        expect_o({nm, "_done"}, 0, 0, 0, '0, '0);
    endtask

    task automatic trigger(input string nm, input logic [31:0] a);
        tick(); miss_complete = 1'b1; next_line_addr = a;
        expect_o({nm, "_trig"}, 0, 0, 0, '0, '0);
        tick(); miss_complete = 1'b0;
        expect_o({nm, "_pend"}, 0, 0, 0, '0, '0);
    endtask

    initial begin : stimulus
        logic [255:0] d_a, d_b, d_c, d_d;
        bit           resp_seen;
        bit           armed;
        int           lat;
        d_a = {8{32'hA5A5_0001}};
        d_b = {8{32'h5A5A_0002}};
        d_c = {8{32'h1234_0003}};
        d_d = {8{32'hCAFE_0004}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        expect_o("reset_idle", 0, 0, 0, '0, '0);

        demand_txn("demand_1000", 32'h0000_1004, d_a);

        trigger("pf_1020", 32'h0000_1020);
        tick();
        expect_o("pf_1020_issue", 0, 0, 1, 32'h0000_1020, '0);
        tick(); mem_resp = 1'b1; mem_rdata = d_b;
        expect_o("pf_1020_fill", 0, 0, 1, 32'h0000_1020, '0);
        tick(); mem_resp = 1'b0;
        expect_o("pf_1020_idle", 0, 0, 0, '0, '0);
        hit_txn("hit_1020", 32'h0000_1020, d_b);
        demand_txn("after_hit_1020", 32'h0000_1020, d_c);

        trigger("merge", 32'h0000_1020);
        tick(); up_read = 1'b1; up_addr = 32'h0000_1020;
        expect_o("merge_inflight", 0, 0, 1, 32'h0000_1020, '0);
        tick();
        expect_o("merge_wait", 0, 0, 1, 32'h0000_1020, '0);
        tick(); mem_resp = 1'b1; mem_rdata = d_d;
        expect_o("merge_resp", 1, 1, 1, 32'h0000_1020, d_d);
        tick(); mem_resp = 1'b0; up_read = 1'b0;
        expect_o("merge_done", 0, 0, 0, '0, '0);
        demand_txn("after_merge", 32'h0000_1020, d_a);

        trigger("other", 32'h0000_1020);
        tick(); up_read = 1'b1; up_addr = 32'h0000_2000;
        expect_o("other_inflight", 0, 0, 1, 32'h0000_1020, '0);
        tick(); mem_resp = 1'b1; mem_rdata = d_c;
        expect_o("other_pf_fill", 0, 0, 1, 32'h0000_1020, '0);
        tick(); mem_resp = 1'b0;
        expect_o("other_idle", 0, 0, 0, '0, '0);
        tick();
        expect_o("other_demand", 0, 0, 1, 32'h0000_2000, '0);
        tick(); mem_resp = 1'b1; mem_rdata = d_b;
        expect_o("other_resp", 1, 0, 1, 32'h0000_2000, d_b);
        tick(); mem_resp = 1'b0; up_read = 1'b0;
        expect_o("other_done", 0, 0, 0, '0, '0);
        hit_txn("other_buf_hit", 32'h0000_1020, d_c);

        trigger("wrap", 32'h0000_0000);
        tick();
        expect_o("wrap_issue", 0, 0, 1, 32'h0000_0000, '0);
        tick(); mem_resp = 1'b1; mem_rdata = d_d;
        expect_o("wrap_fill", 0, 0, 1, 32'h0000_0000, '0);
        tick(); mem_resp = 1'b0;
        expect_o("wrap_idle", 0, 0, 0, '0, '0);

        trigger("rstpf", 32'h0000_3000);
        tick();
        expect_o("rstpf_issue", 0, 0, 1, 32'h0000_3000, '0);
        #2 rst = 1'b0;
        tick(); rst = 1'b1; mem_resp = 1'b1; mem_rdata = d_a;
        expect_o("rstpf_late_resp", 0, 0, 0, '0, '0);
        tick(); mem_resp = 1'b0;
        expect_o("rstpf_quiet", 0, 0, 0, '0, '0);
        demand_txn("rstpf_demand", 32'h0000_0010, d_b);

        resp_seen = 0; armed = 0; lat = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!rst) rst = 1'b1;
            if (mem_resp) begin
                mem_resp = 1'b0;
                armed = 0;
            end else if (mem_read) begin
                if (!armed) begin
                    armed = 1;
                    lat = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    mem_resp = 1'b1;
                    mem_rdata = rnd256();
                    armed = 0;
                end else begin
                    lat--;
                end
            end else begin
                armed = 0;
                mem_resp = ($urandom_range(0, 7) == 0);
                mem_rdata = rnd256();
            end
            if (up_read && resp_seen) begin
                up_read = 1'b0;
            end else if (!up_read && ($urandom_range(0, 2) == 0)) begin
                up_read = 1'b1;
                up_addr = pick_addr();
            end
            miss_complete  = ($urandom_range(0, 5) == 0);
            next_line_addr = pick_addr();
            if ((i % 700) == 350) begin
                #2;
                rst = 1'b0; up_read = 1'b0; mem_resp = 1'b0; miss_complete = 1'b0;
            end
            @(negedge clk);
            resp_seen = up_resp;
        end

        tick(); up_read = 1'b0; mem_resp = 1'b0; miss_complete = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
